calc_entry_fsm: RTL and testbench

- Keypad front-end of the grid calculator; sits between grid_cursor/debouncers and calculator_screen.
- Consumes the cell code under the cursor plus the debounced centre-button pulse.
- Builds operands digit by digit (hex or decimal), latches op1/op2/operator and computes a registered 16-bit result.
- Drives the input_screen/op1/op2/op buses the screen renders.

---
 rtl/calc_entry_fsm.sv | 182 ++++++++++++++++++
 tb/tb_calc_entry_fsm.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_fsm.sv
// Keypad front-end for the grid calculator: builds hex/decimal operands from
// cell-code key pulses, latches op1/op2/operator and registers the 16-bit result.
module calc_entry_fsm #(
   parameter int unsigned W          = 16,
   parameter int unsigned MAX_DIGITS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [4:0]   val,
   input  logic         enter_button,
   input  logic         mode,
   output logic [W-1:0] output_number,
   output logic [W-1:0] op1,
   output logic [W-1:0] op2,
   output logic [2:0]   op,
   output logic         result_valid
);

   localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

   typedef enum logic [1:0] {S_OP1, S_OP2, S_SEL, S_RES} state_t;

   state_t           r_state, w_state_nxt;
   logic [W-1:0]     r_entry, w_entry_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [W-1:0]     r_op1, w_op1_nxt;
   logic [W-1:0]     r_op2, w_op2_nxt;
   logic [2:0]       r_op, w_op_nxt;
   logic [W-1:0]     r_result, w_result_nxt;
   logic             r_valid, w_valid_nxt;
   logic             r_mode_q;
   logic [W-1:0]     r_out;

   logic             w_mode_chg, w_key, w_digit_ok, w_cnt_ok;
   logic             w_ce, w_ac, w_exe, w_oper;
   logic [3:0]       w_digit;
   logic [2:0]       w_opcode;
   logic [W-1:0]     w_hex_shift, w_dec_shift, w_entry_digit;

   function automatic logic [W-1:0] f_alu(input logic [2:0] code,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      case (code)
         3'd0:    f_alu = a + b;
         3'd1:    f_alu = a - b;
         3'd2:    f_alu = a * b;
         3'd3:    f_alu = a & b;
         3'd4:    f_alu = a | b;
         default: f_alu = '0;
      endcase
   endfunction

   // Key decode; a mode change in the same cycle swallows the key.
   assign w_mode_chg    = (mode != r_mode_q);
   assign w_key         = enter_button && !w_mode_chg;
   assign w_digit       = val[3:0];
   assign w_digit_ok    = w_key && !val[4] && (r_mode_q || (w_digit <= 4'd9));
   assign w_cnt_ok      = (r_cnt != CNT_W'(MAX_DIGITS));
   assign w_ce          = w_key && (val == 5'd16);
   assign w_ac          = w_key && (val == 5'd17);
   assign w_exe         = w_key && (val == 5'd18);
   assign w_oper        = w_key && (val >= 5'd19) && (val <= 5'd23);
   assign w_opcode      = 3'(val - 5'd19);
   assign w_hex_shift   = {r_entry[W-5:0], w_digit};
   assign w_dec_shift   = (r_entry << 3) + (r_entry << 1) + W'(w_digit);
   assign w_entry_digit = r_mode_q ? w_hex_shift : w_dec_shift;

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_OP1;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      if (w_ac) begin
         w_state_nxt = S_OP1;
      end else begin
         case (r_state)
            S_OP1: if (w_exe) w_state_nxt = S_OP2;
            S_OP2: if (w_exe) w_state_nxt = S_SEL;
            S_SEL: if (w_oper) w_state_nxt = S_RES;
            S_RES: begin
               if (w_digit_ok)  w_state_nxt = S_OP1;
               else if (w_exe)  w_state_nxt = S_OP2;
            end
            default: w_state_nxt = S_OP1;
         endcase
      end
   end

   // Datapath / output next values
   always_comb begin
      w_entry_nxt  = r_entry;
      w_cnt_nxt    = r_cnt;
      w_op1_nxt    = r_op1;
      w_op2_nxt    = r_op2;
      w_op_nxt     = r_op;
      w_result_nxt = r_result;
      w_valid_nxt  = 1'b0;
      if (w_mode_chg) begin
         w_entry_nxt = '0;
         w_cnt_nxt   = '0;
      end else if (w_ac) begin
         w_entry_nxt  = '0;
         w_cnt_nxt    = '0;
         w_op1_nxt    = '0;
         w_op2_nxt    = '0;
         w_op_nxt     = '0;
         w_result_nxt = '0;
      end else begin
         case (r_state)
            S_OP1, S_OP2: begin
               if (w_digit_ok && w_cnt_ok) begin
                  w_entry_nxt = w_entry_digit;
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
               end else if (w_ce) begin
                  w_entry_nxt = '0;
                  w_cnt_nxt   = '0;
               end else if (w_exe) begin
                  if (r_state == S_OP1) w_op1_nxt = r_entry;
                  else                  w_op2_nxt = r_entry;
                  w_entry_nxt = '0;
                  w_cnt_nxt   = '0;
               end
            end
            S_SEL: begin
               if (w_oper) begin
                  w_op_nxt     = w_opcode;
                  w_result_nxt = f_alu(w_opcode, r_op1, r_op2);
                  w_valid_nxt  = 1'b1;
               end
            end
            S_RES: begin
               if (w_digit_ok) begin
                  w_op1_nxt   = '0;
                  w_op2_nxt   = '0;
                  w_entry_nxt = W'(w_digit);
                  w_cnt_nxt   = CNT_W'(1);
               end else if (w_exe) begin
                  w_op1_nxt   = r_result;
                  w_entry_nxt = '0;
                  w_cnt_nxt   = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_entry  <= '0;
         r_cnt    <= '0;
         r_op1    <= '0;
         r_op2    <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_valid  <= 1'b0;
         r_mode_q <= mode;
         r_out    <= '0;
      end else begin
         r_entry  <= w_entry_nxt;
         r_cnt    <= w_cnt_nxt;
         r_op1    <= w_op1_nxt;
         r_op2    <= w_op2_nxt;
         r_op     <= w_op_nxt;
         r_result <= w_result_nxt;
         r_valid  <= w_valid_nxt;
         r_mode_q <= mode;
         r_out    <= (w_state_nxt == S_RES) ? w_result_nxt : w_entry_nxt;
      end
   end

   assign output_number = r_out;
   assign op1           = r_op1;
   assign op2           = r_op2;
   assign op            = r_op;
   assign result_valid  = r_valid;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed self-checking bench for calc_entry_fsm: entry, operators, chaining,
// mode toggles, reset and AC.
module tb_calc_entry_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  val;
   logic        enter_button;
   logic        mode;
   logic [15:0] output_number, op1, op2;
   logic [2:0]  op;
   logic        result_valid;

   int checks = 0;
   int errors = 0;

   calc_entry_fsm #(.W(16), .MAX_DIGITS(4)) dut (
      .clk(clk), .rst(rst), .val(val), .enter_button(enter_button), .mode(mode),
      .output_number(output_number), .op1(op1), .op2(op2), .op(op),
      .result_valid(result_valid)
   );

   always #5 clk = ~clk;

   // Pulse one key for a single cycle; returns at the following negedge.
   task automatic press(input logic [4:0] v);
      @(negedge clk);
      val = v; enter_button = 1'b1;
      @(negedge clk);
      enter_button = 1'b0; val = 5'd31;
   endtask

   task automatic test_reset;
      rst = 1'b1; val = 5'd31; enter_button = 1'b0; mode = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (output_number !== 16'h0000) begin errors++; $display("FAIL rst_out: got %h exp %h", output_number, 16'h0000); end
      checks++; if (op1 !== 16'h0000) begin errors++; $display("FAIL rst_op1: got %h exp %h", op1, 16'h0000); end
      checks++; if (op2 !== 16'h0000) begin errors++; $display("FAIL rst_op2: got %h exp %h", op2, 16'h0000); end
      checks++; if (op !== 3'd0) begin errors++; $display("FAIL rst_op: got %0d exp %0d", op, 0); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp %b", result_valid, 1'b0); end
   endtask

   task automatic test_hex_entry;
      press(5'd1);
      checks++; if (output_number !== 16'h0001) begin errors++; $display("FAIL hex_d1: got %h exp %h", output_number, 16'h0001); end
      press(5'd2);
      checks++; if (output_number !== 16'h0012) begin errors++; $display("FAIL hex_d2: got %h exp %h", output_number, 16'h0012); end
      press(5'd10);
      checks++; if (output_number !== 16'h012A) begin errors++; $display("FAIL hex_d3: got %h exp %h", output_number, 16'h012A); end
      press(5'd15);
      checks++; if (output_number !== 16'h12AF) begin errors++; $display("FAIL hex_d4: got %h exp %h", output_number, 16'h12AF); end
      press(5'd5);
      checks++; if (output_number !== 16'h12AF) begin errors++; $display("FAIL hex_limit: got %h exp %h", output_number, 16'h12AF); end
      press(5'd20);
      checks++; if (output_number !== 16'h12AF) begin errors++; $display("FAIL op1_oper_ignored: got %h exp %h", output_number, 16'h12AF); end
      press(5'd18);
      checks++; if (op1 !== 16'h12AF) begin errors++; $display("FAIL hex_op1: got %h exp %h", op1, 16'h12AF); end
      checks++; if (output_number !== 16'h0000) begin errors++; $display("FAIL hex_exe_out: got %h exp %h", output_number, 16'h0000); end
   endtask

   task automatic test_add;
      press(5'd3);
      checks++; if (output_number !== 16'h0003) begin errors++; $display("FAIL add_d: got %h exp %h", output_number, 16'h0003); end
      press(5'd18);
      checks++; if (op2 !== 16'h0003) begin errors++; $display("FAIL add_op2: got %h exp %h", op2, 16'h0003); end
      press(5'd7);
      checks++; if (output_number !== 16'h0000) begin errors++; $display("FAIL sel_digit_ignored: got %h exp %h", output_number, 16'h0000); end
      press(5'd19);
      checks++; if (output_number !== 16'h12B2) begin errors++; $display("FAIL add_res: got %h exp %h", output_number, 16'h12B2); end
      checks++; if (op !== 3'd0) begin errors++; $display("FAIL add_op: got %0d exp %0d", op, 0); end
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b exp %b", result_valid, 1'b1); end
      @(negedge clk);
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL add_valid_pulse: got %b exp %b", result_valid, 1'b0); end
   endtask

   task automatic test_noop_codes;
      press(5'd24);
      press(5'd31);
      press(5'd16);
      press(5'd20);
      checks++; if (output_number !== 16'h12B2) begin errors++; $display("FAIL noop_out: got %h exp %h", output_number, 16'h12B2); end
      checks++; if (op !== 3'd0) begin errors++; $display("FAIL noop_op: got %0d exp %0d", op, 0); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL noop_valid: got %b exp %b", result_valid, 1'b0); end
   endtask

   task automatic test_decimal_entry;
      mode = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (output_number !== 16'h12B2) begin errors++; $display("FAIL dec_res_kept: got %h exp %h", output_number, 16'h12B2); end
      press(5'd9);
      checks++; if (output_number !== 16'h0009) begin errors++; $display("FAIL dec_d1: got %h exp %h", output_number, 16'h0009); end
      checks++; if (op1 !== 16'h0000) begin errors++; $display("FAIL dec_op1_clr: got %h exp %h", op1, 16'h0000); end
      press(5'd9);
      checks++; if (output_number !== 16'h0063) begin errors++; $display("FAIL dec_d2: got %h exp %h", output_number, 16'h0063); end
      press(5'd9); press(5'd9);
      checks++; if (output_number !== 16'h270F) begin errors++; $display("FAIL dec_9999: got %h exp %h", output_number, 16'h270F); end
      press(5'd9); press(5'd10);
      checks++; if (output_number !== 16'h270F) begin errors++; $display("FAIL dec_limit: got %h exp %h", output_number, 16'h270F); end
      press(5'd16);
      checks++; if (output_number !== 16'h0000) begin errors++; $display("FAIL dec_ce: got %h exp %h", output_number, 16'h0000); end
      press(5'd10);
      checks++; if (output_number !== 16'h0000) begin errors++; $display("FAIL dec_a_ignored: got %h exp %h", output_number, 16'h0000); end
   endtask

   task automatic test_sub_mul_chain;
      press(5'd1); press(5'd18); press(5'd2); press(5'd18); press(5'd20);
      checks++; if (output_number !== 16'hFFFF) begin errors++; $display("FAIL sub_wrap: got %h exp %h", output_number, 16'hFFFF); end
      checks++; if (op !== 3'd1) begin errors++; $display("FAIL sub_op: got %0d exp %0d", op, 1); end
      press(5'd2); press(5'd5); press(5'd6);
      checks++; if (output_number !== 16'h0100) begin errors++; $display("FAIL dec_256: got %h exp %h", output_number, 16'h0100); end
      press(5'd18); press(5'd2); press(5'd5); press(5'd6); press(5'd18);
      checks++; if (op2 !== 16'h0100) begin errors++; $display("FAIL mul_op2: got %h exp %h", op2, 16'h0100); end
      press(5'd21);
      checks++; if (output_number !== 16'h0000) begin errors++; $display("FAIL mul_trunc: got %h exp %h", output_number, 16'h0000); end
      checks++; if (op !== 3'd2) begin errors++; $display("FAIL mul_op: got %0d exp %0d", op, 2); end
      press(5'd18);
      checks++; if (op1 !== 16'h0000) begin errors++; $display("FAIL chain_op1: got %h exp %h", op1, 16'h0000); end
      press(5'd7); press(5'd18); press(5'd23);
      checks++; if (output_number !== 16'h0007) begin errors++; $display("FAIL chain_or: got %h exp %h", output_number, 16'h0007); end
      press(5'd18);
      checks++; if (op1 !== 16'h0007) begin errors++; $display("FAIL chain2_op1: got %h exp %h", op1, 16'h0007); end
      press(5'd5); press(5'd18); press(5'd22);
      checks++; if (output_number !== 16'h0005) begin errors++; $display("FAIL chain_and: got %h exp %h", output_number, 16'h0005); end
      checks++; if (op !== 3'd3) begin errors++; $display("FAIL and_op: got %0d exp %0d", op, 3); end
   endtask

   task automatic test_mode_toggle;
      mode = 1'b1;
      repeat (2) @(negedge clk);
      press(5'd4); press(5'd2);
      checks++; if (output_number !== 16'h0042) begin errors++; $display("FAIL tog_entry: got %h exp %h", output_number, 16'h0042); end
      press(5'd18);
      press(5'd1); press(5'd7);
      checks++; if (output_number !== 16'h0017) begin errors++; $display("FAIL tog_op2_entry: got %h exp %h", output_number, 16'h0017); end
      @(negedge clk);
      mode = 1'b0; val = 5'd5; enter_button = 1'b1;
      @(negedge clk);
      enter_button = 1'b0; val = 5'd31;
      checks++; if (output_number !== 16'h0000) begin errors++; $display("FAIL tog_clear: got %h exp %h", output_number, 16'h0000); end
      checks++; if (op1 !== 16'h0042) begin errors++; $display("FAIL tog_op1_kept: got %h exp %h", op1, 16'h0042); end
      @(negedge clk);
      checks++; if (output_number !== 16'h0000) begin errors++; $display("FAIL tog_key_dropped: got %h exp %h", output_number, 16'h0000); end
      press(5'd9);
      checks++; if (output_number !== 16'h0009) begin errors++; $display("FAIL tog_dec_digit: got %h exp %h", output_number, 16'h0009); end
      press(5'd18);
      checks++; if (op2 !== 16'h0009) begin errors++; $display("FAIL tog_op2: got %h exp %h", op2, 16'h0009); end
   endtask

   task automatic test_rst_ac;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if ({output_number, op1, op2, op, result_valid} !== 52'd0) begin errors++; $display("FAIL rst_sel: got %h/%h/%h/%0d/%b exp all zero", output_number, op1, op2, op, result_valid); end
      press(5'd3); press(5'd18);
      checks++; if (op1 !== 16'h0003) begin errors++; $display("FAIL rst_state_op1: got %h exp %h", op1, 16'h0003); end
      press(5'd4); press(5'd18); press(5'd19);
      checks++; if (output_number !== 16'h0007) begin errors++; $display("FAIL pre_ac_add: got %h exp %h", output_number, 16'h0007); end
      press(5'd17);
      checks++; if ({output_number, op1, op2, op, result_valid} !== 52'd0) begin errors++; $display("FAIL ac_res: got %h/%h/%h/%0d/%b exp all zero", output_number, op1, op2, op, result_valid); end
      press(5'd3); press(5'd18);
      checks++; if (op1 !== 16'h0003) begin errors++; $display("FAIL ac_state_op1: got %h exp %h", op1, 16'h0003); end
   endtask

   initial begin
      test_reset();
      test_hex_entry();
      test_add();
      test_noop_codes();
      test_decimal_entry();
      test_sub_mul_chain();
      test_mode_toggle();
      test_rst_ac();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
